popcnt_enum: RTL and testbench

POPCNT_ENUM -- requirements
Module: popcnt_enum

---
 rtl/popcnt_enum_pkg.sv | 23 ++
 rtl/popcnt_enum_if.sv | 37 +++
 rtl/popcnt6.sv | 28 ++
 rtl/popcnt_enum.sv | 145 ++++++++++++++
 tb/tb_popcnt_enum.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/popcnt_enum_pkg.sv
// Shared types for the popcount enumerator: FSM state encoding and a
// width-generic popcount helper used when WIDTH differs from 6.
package popcnt_enum_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int unsigned MAX_W = 16;
  localparam int unsigned POP_W = 5;

  // Sum of set bits across a zero-extended 16-bit vector.
  function automatic logic [POP_W-1:0] popcount16(input logic [MAX_W-1:0] v);
    logic [POP_W-1:0] n;
    n = '0;
    for (int unsigned i = 0; i < MAX_W; i++) n = n + POP_W'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/popcnt_enum_if.sv
// Request/stream bundle of the popcount enumerator; o_nEmitted exists only
// when POPCNT_ENUM_NEMITTED_EN is defined.
interface popcnt_enum_if #(
  parameter int unsigned WIDTH = 6
);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic             i_start;
  logic             i_abort;
  logic [CW-1:0]    i_count;
  logic             i_ready;
  logic             o_valid;
  logic [WIDTH-1:0] o_x;
  logic             o_last;
  logic             o_busy;
  logic             o_done;
`ifdef POPCNT_ENUM_NEMITTED_EN
  logic [WIDTH:0]   o_nEmitted;
`endif

  modport master (
    output i_start, i_abort, i_count, i_ready,
`ifdef POPCNT_ENUM_NEMITTED_EN
    input  o_nEmitted,
`endif
    input  o_valid, o_x, o_last, o_busy, o_done
  );

  modport slave (
    input  i_start, i_abort, i_count, i_ready,
`ifdef POPCNT_ENUM_NEMITTED_EN
    output o_nEmitted,
`endif
    output o_valid, o_x, o_last, o_busy, o_done
  );

endinterface

// File: rtl/popcnt6.sv
// Combinational 6-bit popcount: full-adder tree by default, plain bit sum
// when ABSTRACT_MODEL is set.
module popcnt6 #(
  parameter bit ABSTRACT_MODEL = 1'b0
) (
  input  logic [5:0] x_i,
  output logic [2:0] cnt_c_o
);

  generate
    if (ABSTRACT_MODEL) begin : g_abstract
      always_comb begin
        cnt_c_o = '0;
        for (int unsigned i = 0; i < 6; i++) cnt_c_o = cnt_c_o + 3'(x_i[i]);
      end
    end else begin : g_tree
      logic s0, c0, s1, c1, a;
      // Two 3:2 compressors, then a 2-bit add of their results.
      assign s0 = x_i[0] ^ x_i[1] ^ x_i[2];
      assign c0 = (x_i[0] & x_i[1]) | (x_i[0] & x_i[2]) | (x_i[1] & x_i[2]);
      assign s1 = x_i[3] ^ x_i[4] ^ x_i[5];
      assign c1 = (x_i[3] & x_i[4]) | (x_i[3] & x_i[5]) | (x_i[4] & x_i[5]);
      assign a  = s0 & s1;
      assign cnt_c_o = {(c0 & c1) | (c0 & a) | (c1 & a), c0 ^ c1 ^ a, s0 ^ s1};
    end
  endgenerate

endmodule

// File: rtl/popcnt_enum.sv
// Enumerates every WIDTH-bit vector with popcount k in ascending order over a
// valid/ready stream. Optional emitted counter: POPCNT_ENUM_NEMITTED_EN.
module popcnt_enum
  import popcnt_enum_pkg::*;
#(
  parameter int unsigned WIDTH = 6
) (
  input  logic          i_clk,
  input  logic          i_rst,
  popcnt_enum_if.slave  bus
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [CW-1:0]    k_q, k_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [POP_W-1:0] pop_c;
  logic [WIDTH-1:0] last_pat_c;
  logic             match_c;
  logic             all_ones_c;

  generate
    if (WIDTH == 6) begin : g_pc6
      logic [2:0] cnt6;
      popcnt6 #(.ABSTRACT_MODEL(1'b0)) u_popcnt (
        .x_i     (cand_q),
        .cnt_c_o (cnt6)
      );
      assign pop_c = POP_W'(cnt6);
    end else begin : g_pcgen
      assign pop_c = popcount16(MAX_W'(cand_q));
    end
  endgenerate

  assign match_c    = (pop_c == POP_W'(k_q));
  assign all_ones_c = &cand_q;
  // Largest value of popcount k: k ones packed against the MSB.
  assign last_pat_c = ~({WIDTH{1'b1}} >> k_q);

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    k_d     = k_q;
    x_d     = x_q;
    valid_d = valid_q;
    last_d  = last_q;
    if (state_q != ST_IDLE && bus.i_abort) begin
      state_d = ST_IDLE;
      valid_d = 1'b0;
      last_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.i_start && !bus.i_abort) begin
            k_d     = bus.i_count;
            cand_d  = '0;
            state_d = ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (match_c) begin
            x_d     = cand_q;
            valid_d = 1'b1;
            last_d  = (cand_q == last_pat_c);
            state_d = ST_HOLD;
          end else if (all_ones_c) begin
            state_d = ST_DONE;
          end else begin
            cand_d = cand_q + WIDTH'(1);
          end
        end
        ST_HOLD: begin
          if (bus.i_ready) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            if (all_ones_c) begin
              state_d = ST_DONE;
            end else begin
              cand_d  = cand_q + WIDTH'(1);
              state_d = ST_SCAN;
            end
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      cand_q  <= '0;
      k_q     <= '0;
      x_q     <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      k_q     <= k_d;
      x_q     <= x_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.o_valid = valid_q;
  assign bus.o_x     = x_q;
  assign bus.o_last  = last_q;
  assign bus.o_busy  = busy_q;
  assign bus.o_done  = done_q;

`ifdef POPCNT_ENUM_NEMITTED_EN
  logic [WIDTH:0] nemit_q, nemit_d;

  // Counts accepted handshakes since the last accepted start.
  always_comb begin
    nemit_d = nemit_q;
    if (state_q == ST_IDLE && bus.i_start && !bus.i_abort) nemit_d = '0;
    else if (valid_q && bus.i_ready) nemit_d = nemit_q + (WIDTH + 1)'(1);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) nemit_q <= '0;
    else       nemit_q <= nemit_d;
  end

  assign bus.o_nEmitted = nemit_q;
`endif

endmodule

// File: tb/tb_popcnt_enum.sv
// Directed bench for popcnt_enum (WIDTH=6): ordering, o_last, timing,
// backpressure, abort and reset behaviour.
module tb_popcnt_enum;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  popcnt_enum_if #(.WIDTH(6)) bus ();

  popcnt_enum #(.WIDTH(6)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  logic [2:0] ref_cnt;
  popcnt6 #(.ABSTRACT_MODEL(1'b1)) u_ref (
    .x_i     (bus.o_x),
    .cnt_c_o (ref_cnt)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  logic [5:0] got[$];
  int done_cyc;
  int first_valid_cyc;
  int busy_low;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_valid"}, 32'(bus.o_valid), 32'(0));
    chk({tag, "_last"},  32'(bus.o_last),  32'(0));
    chk({tag, "_busy"},  32'(bus.o_busy),  32'(0));
    chk({tag, "_done"},  32'(bus.o_done),  32'(0));
  endtask

  task automatic check_reset(input string tag);
    check_quiet(tag);
    chk({tag, "_x"}, 32'(bus.o_x), 32'(0));
  endtask

  task automatic watch_no_done(input string tag);
    int pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.o_done) pulses++;
    end
    chk(tag, 32'(pulses), 32'(0));
  endtask

  // Starts a run with target k and follows it to o_done, an abort, or a reset.
  task automatic run_enum(input logic [2:0] k, input bit rnd, input int abort_at, input int rst_at);
    logic [5:0] exp_q[$];
    logic [5:0] prev_x = '0;
    bit prev_stall = 1'b0;
    bit rdy;
    int cyc = 0;
    int stalls_left = rnd ? 5 : 0;
    got.delete();
    done_cyc = -1;
    first_valid_cyc = -1;
    busy_low = 0;
    for (int c = 0; c < 64; c++) if ($countones(6'(c)) == int'(k)) exp_q.push_back(6'(c));
    bus.i_count = k;
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    while (cyc < 400) begin
      if (cyc == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        check_reset("rst_asserted");
        @(negedge clk);
        check_reset("rst_held");
        rst = 1'b0;
        return;
      end
      if (bus.o_done) begin
        done_cyc = cyc;
        break;
      end
      if (!bus.o_busy) busy_low++;
      if (prev_stall) begin
        chk("x_stable", 32'(bus.o_x), 32'(prev_x));
        chk("valid_stable", 32'(bus.o_valid), 32'(1));
      end
      rdy = 1'b1;
      if (bus.o_valid) begin
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        if (abort_at >= 0 && got.size() == abort_at) begin
          bus.i_abort = 1'b1;
          bus.i_ready = 1'b1;
          @(negedge clk);
          bus.i_abort = 1'b0;
          check_quiet("abort_idle");
          return;
        end
        if (stalls_left > 0) begin
          rdy = 1'b0;
          stalls_left--;
        end else if (rnd) begin
          rdy = 1'($urandom_range(0, 1));
        end
        if (rdy) begin
          chk("popcnt_ref", 32'(ref_cnt), 32'(k));
          chk("ascending", 32'(got.size() == 0 || bus.o_x > got[$]), 32'(1));
          chk("vector", 32'(bus.o_x),
              (got.size() < exp_q.size()) ? 32'(exp_q[got.size()]) : 32'hDEAD_BEEF);
          chk("last", 32'(bus.o_last), 32'(got.size() == exp_q.size() - 1));
          got.push_back(bus.o_x);
        end
      end
      prev_stall = bus.o_valid && !rdy;
      prev_x = bus.o_x;
      bus.i_ready = rdy;
      @(negedge clk);
      cyc++;
    end
    chk("done_seen", 32'(done_cyc >= 0), 32'(1));
    chk("n_outputs", 32'(got.size()), 32'(exp_q.size()));
    @(negedge clk);
    check_quiet("after_done");
  endtask

  initial begin
    logic [5:0] exp1[6];
    exp1 = '{6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h20};
    rst = 1'b1;
    bus.i_start = 1'b0;
    bus.i_abort = 1'b0;
    bus.i_count = '0;
    bus.i_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;
    @(negedge clk);

    // k=0: single all-zero output, done 64 cycles after it appears
    run_enum(3'd0, 1'b0, -1, -1);
    chk("k0_first_valid", 32'(first_valid_cyc), 32'(1));
    chk("k0_done_cyc", 32'(done_cyc), 32'(65));
    if (got.size() > 0) chk("k0_value", 32'(got[0]), 32'(0));

    // k=1: one-hot walk
    run_enum(3'd1, 1'b0, -1, -1);
    for (int i = 0; i < 6; i++)
      if (i < got.size()) chk("k1_seq", 32'(got[i]), 32'(exp1[i]));
    chk("k1_done_cyc", 32'(done_cyc), 32'(70));

    // k=3 under random backpressure
    run_enum(3'd3, 1'b1, -1, -1);

    // k=7 exceeds WIDTH: no output, full scan
    run_enum(3'd7, 1'b0, -1, -1);
    chk("k7_done_cyc", 32'(done_cyc), 32'(64));
    chk("k7_busy_low", 32'(busy_low), 32'(0));

    // abort while the 4th k=2 output is offered with ready high
    run_enum(3'd2, 1'b0, 3, -1);
    chk("abort_count", 32'(got.size()), 32'(3));
    watch_no_done("abort_no_done");
    run_enum(3'd2, 1'b0, -1, -1);
    chk("k2_done_cyc", 32'(done_cyc), 32'(79));

    // start and abort together in IDLE
    bus.i_start = 1'b1;
    bus.i_abort = 1'b1;
    bus.i_count = 3'd1;
    @(negedge clk);
    bus.i_start = 1'b0;
    bus.i_abort = 1'b0;
    check_quiet("start_abort");
    watch_no_done("start_abort_no_done");

    // reset mid k=4 run, then a full k=4 run
    run_enum(3'd4, 1'b0, -1, 20);
    watch_no_done("rst_no_done");
    run_enum(3'd4, 1'b0, -1, -1);
    chk("k4_done_cyc", 32'(done_cyc), 32'(79));
`ifdef POPCNT_ENUM_NEMITTED_EN
    chk("n_emitted", 32'(bus.o_nEmitted), 32'(15));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
